// File: rtl/display_pkg.sv
// Shared types and sizing for the multiplexed seven-segment scan controller.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

endpackage

// File: rtl/display_slot_timer.sv
// Per-digit slot counter: strobes the end of the anode dead time and the end of the slot.
module display_slot_timer
   import display_pkg::*;
#(
   parameter int SLOT_CYCLES  = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic guard_done,
   output logic slot_done
);

   localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   logic [CW-1:0] cnt_q;

   // Disabling holds the counter at zero so scanning resumes at a clean slot start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!en || slot_done) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign guard_done = en && (cnt_q == CW'(GUARD_CYCLES - 1));
   assign slot_done  = en && (cnt_q == CW'(SLOT_CYCLES - 1));

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit display scanner with guard-banded anodes, blanking and a frame-synchronous shadow register.
module display_scan_controller
   import display_pkg::*;
#(
   parameter int SLOT_CYCLES  = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          load_valid,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
   input  logic                          load_mode,
   input  logic                          load_lzb,
   output logic                          load_ready,
   output logic [DIGIT_W-1:0]            digit_value,
   output logic                          digit_mode,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [IDX_W-1:0]              digit_idx,
   output logic                          frame_tick
);

   scan_state_t                   state_q, state_d;
   logic                          guard_done, slot_done;
   logic [IDX_W-1:0]              idx_q;
   logic [NUM_DIGITS*DIGIT_W-1:0] act_data, shd_data;
   logic                          act_mode, act_lzb, shd_mode, shd_lzb, shd_full;
   logic                          accept, commit, blank;
   logic [NUM_DIGITS-1:0]         lz_mask;

   display_slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .GUARD_CYCLES(GUARD_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .guard_done(guard_done),
      .slot_done (slot_done)
   );

   assign frame_tick = slot_done && (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign load_ready = !shd_full;
   assign accept     = load_valid && load_ready;
   // With the scan stopped there is no tearing to avoid, so a pending word commits at once.
   assign commit     = shd_full && (frame_tick || !en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GUARD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = GUARD;
      end else begin
         case (state_q)
            GUARD:   if (guard_done) state_d = DRIVE;
            DRIVE:   if (slot_done)  state_d = GUARD;
            default: state_d = GUARD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (!en) begin
         idx_q <= '0;
      end else if (slot_done) begin
         idx_q <= idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_data <= '0;
         shd_mode <= 1'b0;
         shd_lzb  <= 1'b0;
         shd_full <= 1'b0;
         act_data <= '0;
         act_mode <= 1'b0;
         act_lzb  <= 1'b0;
      end else begin
         if (commit) begin
            act_data <= shd_data;
            act_mode <= shd_mode;
            act_lzb  <= shd_lzb;
            shd_full <= 1'b0;
         end
         if (accept) begin
            shd_data <= load_data;
            shd_mode <= load_mode;
            shd_lzb  <= load_lzb;
            shd_full <= 1'b1;
         end
      end
   end

   assign digit_idx   = idx_q;
   assign digit_value = act_data[idx_q*DIGIT_W +: DIGIT_W];
   assign digit_mode  = act_mode;

   // lz_mask[i] is set when digit i and every digit above it are zero.
   always_comb begin
      logic run;
      run     = 1'b1;
      lz_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run        = run && (act_data[i*DIGIT_W +: DIGIT_W] == '0);
         lz_mask[i] = run;
      end
   end

   always_comb begin
      blank = 1'b0;
      if (act_lzb && (idx_q != '0) && lz_mask[idx_q]) blank = 1'b1;
      if (!act_mode && (digit_value > DIGIT_W'(9)))   blank = 1'b1;
   end

   always_comb begin
      an = '1;
      if (en && (state_q == DRIVE) && !blank) an[idx_q] = 1'b0;
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed and randomized bench for display_scan_controller against a frame-position reference model.
module tb_display_scan_controller;

   localparam int SLOT  = 8;
   localparam int GUARD = 2;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_mode;
   logic        load_lzb;
   logic        load_ready;
   logic [3:0]  digit_value;
   logic        digit_mode;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;

   // reference model: position within the frame plus the two display words
   int          pos;
   logic [15:0] m_act, m_shd;
   logic        m_amode, m_alzb, m_smode, m_slzb, m_full;

   display_scan_controller #(
      .SLOT_CYCLES (SLOT),
      .GUARD_CYCLES(GUARD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_mode  (load_mode),
      .load_lzb   (load_lzb),
      .load_ready (load_ready),
      .digit_value(digit_value),
      .digit_mode (digit_mode),
      .an         (an),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      pos     = 0;
      m_act   = '0;
      m_shd   = '0;
      m_amode = 1'b0;
      m_alzb  = 1'b0;
      m_smode = 1'b0;
      m_slzb  = 1'b0;
      m_full  = 1'b0;
   endtask

   task automatic model_check();
      int          slot;
      logic [15:0] upper;
      logic [3:0]  nib;
      logic [3:0]  ean;
      bit          guard, blank;
      slot  = pos / SLOT;
      guard = (pos % SLOT) < GUARD;
      upper = m_act >> (4 * slot);
      nib   = upper[3:0];
      blank = (m_alzb && slot != 0 && upper == 16'h0) || (!m_amode && nib > 4'd9);
      ean   = (!en || guard || blank) ? 4'hF : ~(4'b0001 << slot);
      chk("an", 16'(an), 16'(ean));
      chk("digit_idx", 16'(digit_idx), 16'(slot));
      chk("digit_value", 16'(digit_value), 16'(nib));
      chk("digit_mode", 16'(digit_mode), 16'(m_amode));
      chk("frame_tick", 16'(frame_tick), 16'(en && pos == FRAME - 1));
      chk("load_ready", 16'(load_ready), 16'(!m_full));
   endtask

   task automatic model_edge();
      bit ft;
      bit acc;
      ft  = en && pos == FRAME - 1;
      acc = load_valid && !m_full;
      if (m_full && (ft || !en)) begin
         m_act   = m_shd;
         m_amode = m_smode;
         m_alzb  = m_slzb;
         m_full  = 1'b0;
      end
      if (acc) begin
         m_shd   = load_data;
         m_smode = load_mode;
         m_slzb  = load_lzb;
         m_full  = 1'b1;
      end
      pos = en ? (pos + 1) % FRAME : 0;
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_load(input logic [15:0] d, input logic m, input logic z);
      bit done;
      done       = 1'b0;
      load_valid = 1'b1;
      load_data  = d;
      load_mode  = m;
      load_lzb   = z;
      for (int k = 0; k < 4 * FRAME; k++) begin
         if (load_ready) begin
            step();
            done = 1'b1;
            break;
         end
         step();
      end
      load_valid = 1'b0;
      if (!done) chk("load_timeout", 16'(load_ready), 16'h1);
   endtask

   task automatic wait_ft_and_commit();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (frame_tick) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk("frame_tick_seen", 16'(seen), 16'h1);
      step();
   endtask

   // Starting at the digit-0 guard, check one whole frame against literal expectations.
   task automatic frame_chk(input logic [15:0] ans, input logic [15:0] vals);
      logic [15:0] a_sh, v_sh;
      for (int c = 0; c < FRAME; c++) begin
         a_sh = ans >> (4 * (c / SLOT));
         v_sh = vals >> (4 * (c / SLOT));
         chk("frame_an", 16'(an), (c % SLOT < GUARD) ? 16'hF : 16'(a_sh[3:0]));
         chk("frame_val", 16'(digit_value), 16'(v_sh[3:0]));
         chk("frame_tick_pos", 16'(frame_tick), 16'(c == FRAME - 1));
         step();
      end
   endtask

   task automatic do_reset();
      #2;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      #1;
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_value", 16'(digit_value), 16'h0);
      chk("rst_mode", 16'(digit_mode), 16'h0);
      chk("rst_idx", 16'(digit_idx), 16'h0);
      chk("rst_tick", 16'(frame_tick), 16'h0);
      chk("rst_ready", 16'(load_ready), 16'h1);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      en         = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_mode  = 1'b0;
      load_lzb   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      en = 1'b1;

      // 1234 hex, no blanking
      do_load(16'h1234, 1'b1, 1'b0);
      wait_ft_and_commit();
      frame_chk(16'h7BDE, 16'h1234);

      // 0070 decimal with leading-zero blanking
      do_load(16'h0070, 1'b0, 1'b1);
      wait_ft_and_commit();
      frame_chk(16'hFFDE, 16'h0070);

      // 00A5 decimal blanks the A; hex shows it
      do_load(16'h00A5, 1'b0, 1'b0);
      wait_ft_and_commit();
      frame_chk(16'h7BFE, 16'h00A5);
      do_load(16'h00A5, 1'b1, 1'b0);
      wait_ft_and_commit();
      frame_chk(16'h7BDE, 16'h00A5);

      // back-to-back loads mid-frame
      for (int k = 0; k < 5; k++) step();
      do_load(16'h5678, 1'b1, 1'b0);
      chk("stall_ready", 16'(load_ready), 16'h0);
      chk("no_tear", 16'(digit_value), 16'h5);
      do_load(16'h9ABC, 1'b1, 1'b0);
      wait_ft_and_commit();
      frame_chk(16'h7BDE, 16'h9ABC);

      // drop en mid-DRIVE of digit 2, load while disabled, re-enable
      for (int k = 0; k < 2 * SLOT + GUARD + 2; k++) step();
      chk("pre_disable_an", 16'(an), 16'hB);
      en = 1'b0;
      step();
      chk("disabled_an", 16'(an), 16'hF);
      do_load(16'h0F00, 1'b1, 1'b1);
      step();
      chk("disabled_commit_ready", 16'(load_ready), 16'h1);
      en = 1'b1;
      chk("reenable_idx", 16'(digit_idx), 16'h0);
      chk("reenable_an", 16'(an), 16'hF);
      frame_chk(16'hFBDE, 16'h0F00);

      // reset during a pending load
      for (int k = 0; k < 3; k++) step();
      do_load(16'h4321, 1'b1, 1'b0);
      chk("pending_ready", 16'(load_ready), 16'h0);
      do_reset();
      for (int k = 0; k < FRAME + 4; k++) step();

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = 16'($urandom);
         load_mode  = 1'($urandom);
         load_lzb   = 1'($urandom);
         if ($urandom_range(0, 60) == 0) en = ~en;
         if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
